// File: rtl/epd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : epd_pkg
// Description : Shared types and constants for the Ethernet frame checker.
//               Holds the parser state encoding, the preamble/SFD byte
//               values, the CRC-32 constants and the Ethernet field lengths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package epd_pkg;

    // Parser states, one-hot-free binary encoding with explicit width.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_DST     = 3'd2,
        ST_SRC     = 3'd3,
        ST_TYPE    = 3'd4,
        ST_PAYLOAD = 3'd5,
        ST_IFG     = 3'd6,
        ST_DROP    = 3'd7
    } epd_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    // Reflected CRC-32: polynomial, seed, and the register value left behind
    // once a correct FCS has been shifted through (no final inversion).
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    localparam int          ADDR_BYTES    = 6;
    localparam int          TL_BYTES      = 2;
    localparam int          FCS_BYTES     = 4;

    // Type/length values at or below this are lengths, above are EtherTypes.
    localparam int          TL_MAX_LEN    = 1500;

endpackage
`default_nettype wire

// File: rtl/crc32_byte_update.sv
`default_nettype none
// ============================================================================
// Module      : crc32_byte_update
// Description : Combinational one-byte step of the reflected CRC-32. The
//               byte is consumed LSB first, matching Ethernet bit order.
// Ports       : i_crc  [31:0] - current CRC register
//               i_data [7:0]  - byte to absorb
//               o_crc  [31:0] - CRC register after the byte
// Revision    : 1.0 - initial release
// ============================================================================
module crc32_byte_update
    import epd_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = i_crc;
        for (int b = 0; b < 8; b++) begin
            if (w_crc[0] ^ i_data[b]) begin
                w_crc = (w_crc >> 1) ^ CRC_POLY;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
        o_crc = w_crc;
    end

endmodule
`default_nettype wire

// File: rtl/epd_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : epd_frame_checker
// Description : Byte-wide Ethernet frame parser and checker. Walks the
//               preamble/SFD, destination, source, type/length, payload and
//               FCS of each frame; checks CRC-32, payload size bounds and the
//               minimum inter-frame gap; optionally filters on destination.
//               Reports one-cycle field pulses and saturating good/error
//               frame counters.
// Ports       : clock                - single clock, rising edge
//               reset                - asynchronous, active-high
//               data [7:0]           - frame byte, sampled every cycle
//               control              - high while a frame byte is on data
//               my_addr [47:0]       - station address; my_addr[7:0] is the
//                                      first address byte on the wire
//               preamble_valid       - pulse after SFD accepted
//               dst_addr_valid       - pulse after last destination byte
//               src_addr_valid       - pulse after last source byte
//               type_length_valid    - pulse after second type/length byte
//               packet_size_valid    - pulse at end of frame, size in bounds
//               crc_valid            - pulse at end of frame, FCS correct
//               frame_ok             - pulse, frame good and counted
//               frame_err            - pulse, frame aborted or bad
//               valid_packet_counter - good frames, saturating
//               error_counter        - bad frames, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module epd_frame_checker
    import epd_pkg::*;
#(
    parameter int CNT_W          = 4,
    parameter int MIN_PAYLOAD    = 46,
    parameter int MAX_PAYLOAD    = 1500,
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_MIN        = 12,
    parameter int FILTER_EN      = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       data,
    input  logic             control,
    input  logic [47:0]      my_addr,
    output logic             preamble_valid,
    output logic             dst_addr_valid,
    output logic             src_addr_valid,
    output logic             type_length_valid,
    output logic             packet_size_valid,
    output logic             crc_valid,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [CNT_W-1:0] valid_packet_counter,
    output logic [CNT_W-1:0] error_counter
);

    // PAYLOAD byte count includes the FCS; it stops one past the largest
    // legal count so oversize frames stay distinguishable.
    localparam int c_PAY_SAT = MAX_PAYLOAD + FCS_BYTES + 1;
    localparam int c_PAY_W   = $clog2(c_PAY_SAT + 1);
    localparam int c_IFG_W   = $clog2(IFG_MIN + 1) + 1;
    localparam int c_FLD_W   = 8;
    localparam int c_MIN_CNT = MIN_PAYLOAD + FCS_BYTES;
    localparam int c_MAX_CNT = MAX_PAYLOAD + FCS_BYTES;

    localparam logic [c_PAY_W-1:0] c_PAY_SAT_V = c_PAY_W'(c_PAY_SAT);
    localparam logic [c_IFG_W-1:0] c_IFG_ONE   = c_IFG_W'(1);
    localparam logic [c_FLD_W-1:0] c_FLD_ONE   = c_FLD_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    epd_state_t         r_state;
    logic [c_FLD_W-1:0] r_fld_cnt;
    logic [c_PAY_W-1:0] r_pay_cnt;
    logic [c_IFG_W-1:0] r_ifg_cnt;
    logic [15:0]        r_tl;
    logic [31:0]        r_crc;
    logic               r_dst_mine;
    logic               r_dst_bcast;
    logic               r_pre_pulse;
    logic               r_dst_pulse;
    logic               r_src_pulse;
    logic               r_tl_pulse;
    logic               r_size_pulse;
    logic               r_crc_pulse;
    logic               r_ok_pulse;
    logic               r_err_pulse;
    logic [CNT_W-1:0]   r_good_cnt;
    logic [CNT_W-1:0]   r_bad_cnt;

    // ------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------
    epd_state_t         w_state_next;
    logic [c_FLD_W-1:0] w_fld_cnt_next;
    logic [c_PAY_W-1:0] w_pay_cnt_next;
    logic [c_IFG_W-1:0] w_ifg_cnt_next;
    logic [15:0]        w_tl_next;
    logic               w_mine_next;
    logic               w_bcast_next;
    logic               w_pre_pulse;
    logic               w_dst_pulse;
    logic               w_src_pulse;
    logic               w_tl_pulse;
    logic               w_size_pulse;
    logic               w_crc_pulse;
    logic               w_ok_pulse;
    logic               w_err_pulse;

    logic [7:0]         w_my_byte;
    logic [31:0]        w_crc_upd;
    logic [31:0]        w_pay_ext;
    logic [31:0]        w_tl_need;
    logic               w_size_ok;
    logic               w_crc_ok;
    logic               w_crc_en;
    logic               w_crc_clr;

    crc32_byte_update u_crc (
        .i_crc  (r_crc),
        .i_data (data),
        .o_crc  (w_crc_upd)
    );

    // Address byte expected at the current destination position.
    always_comb begin
        w_my_byte = my_addr[7:0];
        case (r_fld_cnt[2:0])
            3'd1:    w_my_byte = my_addr[15:8];
            3'd2:    w_my_byte = my_addr[23:16];
            3'd3:    w_my_byte = my_addr[31:24];
            3'd4:    w_my_byte = my_addr[39:32];
            3'd5:    w_my_byte = my_addr[47:40];
            default: w_my_byte = my_addr[7:0];
        endcase
    end

    // End-of-frame checks. r_pay_cnt counts payload plus FCS, so every
    // payload bound is shifted by FCS_BYTES instead of subtracting.
    assign w_pay_ext = 32'(r_pay_cnt);
    assign w_tl_need = 32'(r_tl) + 32'(FCS_BYTES);
    assign w_size_ok = (w_pay_ext >= c_MIN_CNT) && (w_pay_ext <= c_MAX_CNT) &&
                       ((32'(r_tl) > TL_MAX_LEN) || (w_pay_ext >= w_tl_need));
    assign w_crc_ok  = (r_crc == CRC_RESIDUE);

    assign w_crc_clr = (r_state == ST_IDLE) || (r_state == ST_PRE);
    assign w_crc_en  = control && ((r_state == ST_DST) || (r_state == ST_SRC) ||
                                   (r_state == ST_TYPE) || (r_state == ST_PAYLOAD));

    // ------------------------------------------------------------------
    // Next-state and pulse logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_fld_cnt_next = r_fld_cnt;
        w_pay_cnt_next = r_pay_cnt;
        w_ifg_cnt_next = r_ifg_cnt;
        w_tl_next      = r_tl;
        w_mine_next    = r_dst_mine;
        w_bcast_next   = r_dst_bcast;
        w_pre_pulse    = 1'b0;
        w_dst_pulse    = 1'b0;
        w_src_pulse    = 1'b0;
        w_tl_pulse     = 1'b0;
        w_size_pulse   = 1'b0;
        w_crc_pulse    = 1'b0;
        w_ok_pulse     = 1'b0;
        w_err_pulse    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // The byte that starts a frame is the first preamble byte.
                if (control && (data == PREAMBLE_BYTE)) begin
                    w_state_next   = ST_PRE;
                    w_fld_cnt_next = c_FLD_ONE;
                end
            end

            ST_PRE: begin
                if (!control) begin
                    w_err_pulse    = 1'b1;
                    w_state_next   = ST_IFG;
                    w_ifg_cnt_next = c_IFG_ONE;
                end else if ((data == PREAMBLE_BYTE) &&
                             (32'(r_fld_cnt) < PREAMBLE_BYTES)) begin
                    w_fld_cnt_next = r_fld_cnt + c_FLD_ONE;
                end else if ((data == SFD_BYTE) &&
                             (32'(r_fld_cnt) == PREAMBLE_BYTES)) begin
                    w_pre_pulse    = 1'b1;
                    w_state_next   = ST_DST;
                    w_fld_cnt_next = '0;
                    w_mine_next    = 1'b1;
                    w_bcast_next   = 1'b1;
                end else begin
                    // Early SFD, too many 55s or any other byte.
                    w_err_pulse  = 1'b1;
                    w_state_next = ST_DROP;
                end
            end

            ST_DST: begin
                if (!control) begin
                    w_err_pulse    = 1'b1;
                    w_state_next   = ST_IFG;
                    w_ifg_cnt_next = c_IFG_ONE;
                end else begin
                    w_mine_next  = r_dst_mine && (data == w_my_byte);
                    w_bcast_next = r_dst_bcast && (data == 8'hFF);
                    if (32'(r_fld_cnt) == ADDR_BYTES - 1) begin
                        w_dst_pulse    = 1'b1;
                        w_fld_cnt_next = '0;
                        // Foreign frames are silently skipped, not errors.
                        if ((FILTER_EN != 0) && !w_mine_next && !w_bcast_next) begin
                            w_state_next = ST_DROP;
                        end else begin
                            w_state_next = ST_SRC;
                        end
                    end else begin
                        w_fld_cnt_next = r_fld_cnt + c_FLD_ONE;
                    end
                end
            end

            ST_SRC: begin
                if (!control) begin
                    w_err_pulse    = 1'b1;
                    w_state_next   = ST_IFG;
                    w_ifg_cnt_next = c_IFG_ONE;
                end else if (32'(r_fld_cnt) == ADDR_BYTES - 1) begin
                    w_src_pulse    = 1'b1;
                    w_fld_cnt_next = '0;
                    w_state_next   = ST_TYPE;
                end else begin
                    w_fld_cnt_next = r_fld_cnt + c_FLD_ONE;
                end
            end

            ST_TYPE: begin
                if (!control) begin
                    w_err_pulse    = 1'b1;
                    w_state_next   = ST_IFG;
                    w_ifg_cnt_next = c_IFG_ONE;
                end else begin
                    // Big-endian: the first byte ends up in the high half.
                    w_tl_next = {r_tl[7:0], data};
                    if (32'(r_fld_cnt) == TL_BYTES - 1) begin
                        w_tl_pulse     = 1'b1;
                        w_fld_cnt_next = '0;
                        w_pay_cnt_next = '0;
                        w_state_next   = ST_PAYLOAD;
                    end else begin
                        w_fld_cnt_next = r_fld_cnt + c_FLD_ONE;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (control) begin
                    if (r_pay_cnt != c_PAY_SAT_V) begin
                        w_pay_cnt_next = r_pay_cnt + 1'b1;
                    end
                end else begin
                    w_size_pulse   = w_size_ok;
                    w_crc_pulse    = w_crc_ok;
                    w_ok_pulse     = w_size_ok && w_crc_ok;
                    w_err_pulse    = !(w_size_ok && w_crc_ok);
                    w_state_next   = ST_IFG;
                    w_ifg_cnt_next = c_IFG_ONE;
                end
            end

            ST_IFG: begin
                if (control) begin
                    // Next frame started inside the gap.
                    w_err_pulse  = 1'b1;
                    w_state_next = ST_DROP;
                end else if ((32'(r_ifg_cnt) + 32'd1) >= IFG_MIN) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_ifg_cnt_next = r_ifg_cnt + c_IFG_ONE;
                end
            end

            ST_DROP: begin
                if (!control) begin
                    w_state_next   = ST_IFG;
                    w_ifg_cnt_next = c_IFG_ONE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath, pulses and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fld_cnt    <= '0;
            r_pay_cnt    <= '0;
            r_ifg_cnt    <= '0;
            r_tl         <= '0;
            r_crc        <= CRC_INIT;
            r_dst_mine   <= 1'b0;
            r_dst_bcast  <= 1'b0;
            r_pre_pulse  <= 1'b0;
            r_dst_pulse  <= 1'b0;
            r_src_pulse  <= 1'b0;
            r_tl_pulse   <= 1'b0;
            r_size_pulse <= 1'b0;
            r_crc_pulse  <= 1'b0;
            r_ok_pulse   <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_good_cnt   <= '0;
            r_bad_cnt    <= '0;
        end else begin
            r_fld_cnt    <= w_fld_cnt_next;
            r_pay_cnt    <= w_pay_cnt_next;
            r_ifg_cnt    <= w_ifg_cnt_next;
            r_tl         <= w_tl_next;
            r_dst_mine   <= w_mine_next;
            r_dst_bcast  <= w_bcast_next;
            r_pre_pulse  <= w_pre_pulse;
            r_dst_pulse  <= w_dst_pulse;
            r_src_pulse  <= w_src_pulse;
            r_tl_pulse   <= w_tl_pulse;
            r_size_pulse <= w_size_pulse;
            r_crc_pulse  <= w_crc_pulse;
            r_ok_pulse   <= w_ok_pulse;
            r_err_pulse  <= w_err_pulse;

            // CRC is reseeded while hunting for the next frame and runs over
            // every byte from the first destination byte through the FCS.
            if (w_crc_clr) begin
                r_crc <= CRC_INIT;
            end else if (w_crc_en) begin
                r_crc <= w_crc_upd;
            end

            if (w_ok_pulse && (r_good_cnt != {CNT_W{1'b1}})) begin
                r_good_cnt <= r_good_cnt + 1'b1;
            end
            if (w_err_pulse && (r_bad_cnt != {CNT_W{1'b1}})) begin
                r_bad_cnt <= r_bad_cnt + 1'b1;
            end
        end
    end

    assign preamble_valid       = r_pre_pulse;
    assign dst_addr_valid       = r_dst_pulse;
    assign src_addr_valid       = r_src_pulse;
    assign type_length_valid    = r_tl_pulse;
    assign packet_size_valid    = r_size_pulse;
    assign crc_valid            = r_crc_pulse;
    assign frame_ok             = r_ok_pulse;
    assign frame_err            = r_err_pulse;
    assign valid_packet_counter = r_good_cnt;
    assign error_counter        = r_bad_cnt;

endmodule
`default_nettype wire
